// File: rtl/data_lane_destriper_if.sv
// Handshake bundle between the lane-aligned striped input side and the
// serialized output side of data_lane_destriper.
interface data_lane_destriper_if #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] striped_data_i;
    logic                                 striped_data_valid_i;
    logic                                 striped_data_ready_o;
    logic [NUM_LANES-1:0]                 lane_enable_i;
    logic [DATA_WIDTH-1:0]                destriped_data_o;
    logic                                 destriped_data_valid_o;
    logic                                 destriped_data_ready_i;
    logic                                 set_done_o;
    logic                                 lane_cfg_err_o;

    modport slave (
        input  striped_data_i, striped_data_valid_i, lane_enable_i, destriped_data_ready_i,
        output striped_data_ready_o, destriped_data_o, destriped_data_valid_o,
               set_done_o, lane_cfg_err_o
    );

    modport master (
        output striped_data_i, striped_data_valid_i, lane_enable_i, destriped_data_ready_i,
        input  striped_data_ready_o, destriped_data_o, destriped_data_valid_o,
               set_done_o, lane_cfg_err_o
    );
endinterface

// File: rtl/data_lane_destriper.sv
// Captures one lane-aligned symbol set and serializes lanes 0..K-1 onto a
// single ready/valid output, accepting the next set on the last handshake.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | no symbols buffered, ready for a new set
// ST_DRAIN | buffered symbols remain to be output
module data_lane_destriper #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    data_lane_destriper_if.slave   bus
);
    localparam int CW = $clog2(NUM_LANES + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                               state_q, state_d;
    logic [CW-1:0]                        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                        k_q, k_d;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] buf_q, buf_d;

    logic [CW-1:0]         k_in;
    logic                  run;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_hs;
    logic                  last_sym;
    logic                  in_ready;
    logic                  in_fire;
    logic                  capture;

    // Active lane count: ones above the first zero do not count.
    always_comb begin
        k_in = '0;
        run  = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (run && bus.lane_enable_i[i]) begin
                k_in = CW'(i + 1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        out_valid = !rst_i && (state_q == ST_DRAIN);
        out_data  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (out_valid && (rd_ptr_q == CW'(i))) begin
                out_data = buf_q[i];
            end
        end
        out_hs   = out_valid && bus.destriped_data_ready_i;
        last_sym = (rd_ptr_q + CW'(1)) == k_q;
        in_ready = !rst_i && ((state_q == ST_IDLE) || (out_hs && last_sym));
        in_fire  = bus.striped_data_valid_i && in_ready;
        capture  = in_fire && (k_in != '0);
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        k_d      = k_q;
        buf_d    = buf_q;
        if (out_hs) begin
            if (last_sym) begin
                state_d  = ST_IDLE;
                rd_ptr_d = '0;
            end else begin
                rd_ptr_d = rd_ptr_q + CW'(1);
            end
        end
        // A capture on the final handshake overrides the return to idle.
        if (capture) begin
            state_d  = ST_DRAIN;
            rd_ptr_d = '0;
            k_d      = k_in;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (CW'(i) < k_in) begin
                    buf_d[i] = bus.striped_data_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            k_q      <= '0;
            buf_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            k_q      <= k_d;
            buf_q    <= buf_d;
        end
    end

    assign bus.striped_data_ready_o   = in_ready;
    assign bus.destriped_data_o       = out_data;
    assign bus.destriped_data_valid_o = out_valid;
    assign bus.set_done_o             = out_hs && last_sym;
    assign bus.lane_cfg_err_o         = in_fire && (k_in == '0);
endmodule

// File: tb/tb_data_lane_destriper.sv
// Bench for data_lane_destriper: directed scenarios plus a randomized run
// against a queue-based model of the serialized output stream.
module tb_data_lane_destriper;
    localparam int NL = 4;
    localparam int DW = 8;
    typedef logic [NL-1:0][DW-1:0] set_t;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    data_lane_destriper_if #(.NUM_LANES(NL), .DATA_WIDTH(DW)) bus ();

    data_lane_destriper #(.NUM_LANES(NL), .DATA_WIDTH(DW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    function automatic int kcount(input logic [NL-1:0] en);
        for (int i = 0; i < NL; i++) begin
            if (!en[i]) return i;
        end
        return NL;
    endfunction

    function automatic set_t rand_set();
        set_t s;
        for (int i = 0; i < NL; i++) s[i] = DW'($urandom);
        return s;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic rst, input logic v, input logic [NL-1:0] en,
                         input set_t d, input logic rdy);
        @(negedge clk_i);
        rst_i                      = rst;
        bus.striped_data_valid_i   = v;
        bus.lane_enable_i          = en;
        bus.striped_data_i         = d;
        bus.destriped_data_ready_i = rdy;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 4'hF, rand_set(), 1'b1);
        n_cmp++; if (bus.striped_data_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", bus.striped_data_ready_o); end
        n_cmp++; if (bus.destriped_data_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.destriped_data_valid_o); end
        n_cmp++; if (bus.destriped_data_o !== '0) begin n_err++; $display("FAIL reset_data: got %h expected 00", bus.destriped_data_o); end
        n_cmp++; if (bus.set_done_o !== 1'b0 || bus.lane_cfg_err_o !== 1'b0) begin n_err++; $display("FAIL reset_pulses: got done=%b err=%b expected 0 0", bus.set_done_o, bus.lane_cfg_err_o); end
        drive(1'b1, 1'b0, 4'h0, '0, 1'b1);
        n_cmp++; if (bus.lane_cfg_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", bus.lane_cfg_err_o); end
        drive(1'b0, 1'b0, 4'hF, '0, 1'b1);
        n_cmp++; if (bus.striped_data_ready_o !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b expected 1", bus.striped_data_ready_o); end
        n_cmp++; if (bus.destriped_data_valid_o !== 1'b0) begin n_err++; $display("FAIL release_valid: got %b expected 0", bus.destriped_data_valid_o); end
    endtask

    task automatic test_full_set();
        set_t a = rand_set();
        drive(1'b0, 1'b1, 4'hF, a, 1'b1);
        n_cmp++; if (bus.striped_data_ready_o !== 1'b1) begin n_err++; $display("FAIL full_capture_ready: got %b expected 1", bus.striped_data_ready_o); end
        for (int i = 0; i < NL; i++) begin
            drive(1'b0, 1'b0, 4'hF, rand_set(), 1'b1);
            n_cmp++; if (bus.destriped_data_valid_o !== 1'b1 || bus.destriped_data_o !== a[i]) begin n_err++; $display("FAIL full_sym[%0d]: got v=%b d=%h expected v=1 d=%h", i, bus.destriped_data_valid_o, bus.destriped_data_o, a[i]); end
            n_cmp++; if (bus.set_done_o !== (i == NL - 1)) begin n_err++; $display("FAIL full_done[%0d]: got %b expected %b", i, bus.set_done_o, (i == NL - 1)); end
            n_cmp++; if (bus.striped_data_ready_o !== (i == NL - 1)) begin n_err++; $display("FAIL full_ready[%0d]: got %b expected %b", i, bus.striped_data_ready_o, (i == NL - 1)); end
        end
        drive(1'b0, 1'b0, 4'hF, '0, 1'b1);
        n_cmp++; if (bus.destriped_data_valid_o !== 1'b0 || bus.destriped_data_o !== '0) begin n_err++; $display("FAIL full_idle: got v=%b d=%h expected v=0 d=00", bus.destriped_data_valid_o, bus.destriped_data_o); end
    endtask

    task automatic test_back_to_back();
        set_t cur = rand_set();
        set_t nxt;
        logic offer;
        drive(1'b0, 1'b1, 4'hF, cur, 1'b1);
        for (int s = 0; s < 3; s++) begin
            nxt = rand_set();
            for (int i = 0; i < NL; i++) begin
                offer = (i == NL - 1) && (s < 2);
                drive(1'b0, offer, 4'hF, offer ? nxt : rand_set(), 1'b1);
                n_cmp++; if (bus.destriped_data_valid_o !== 1'b1 || bus.destriped_data_o !== cur[i]) begin n_err++; $display("FAIL b2b_sym[%0d][%0d]: got v=%b d=%h expected v=1 d=%h", s, i, bus.destriped_data_valid_o, bus.destriped_data_o, cur[i]); end
                n_cmp++; if (bus.striped_data_ready_o !== (i == NL - 1)) begin n_err++; $display("FAIL b2b_ready[%0d][%0d]: got %b expected %b", s, i, bus.striped_data_ready_o, (i == NL - 1)); end
            end
            cur = nxt;
        end
        drive(1'b0, 1'b0, 4'hF, '0, 1'b1);
        n_cmp++; if (bus.destriped_data_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b expected 0", bus.destriped_data_valid_o); end
    endtask

    task automatic test_partial_lanes();
        logic [NL-1:0] pats [4] = '{4'b0011, 4'b1011, 4'b0111, 4'b0001};
        set_t c;
        int   k;
        foreach (pats[p]) begin
            c = rand_set();
            k = kcount(pats[p]);
            drive(1'b0, 1'b1, pats[p], c, 1'b1);
            for (int i = 0; i < k; i++) begin
                // Lane enables wander mid-set; the latched count must win.
                drive(1'b0, 1'b0, NL'($urandom), rand_set(), 1'b1);
                n_cmp++; if (bus.destriped_data_valid_o !== 1'b1 || bus.destriped_data_o !== c[i]) begin n_err++; $display("FAIL part_sym[%0d][%0d]: got v=%b d=%h expected v=1 d=%h", p, i, bus.destriped_data_valid_o, bus.destriped_data_o, c[i]); end
                n_cmp++; if (bus.set_done_o !== (i == k - 1)) begin n_err++; $display("FAIL part_done[%0d][%0d]: got %b expected %b", p, i, bus.set_done_o, (i == k - 1)); end
            end
            drive(1'b0, 1'b0, 4'hF, '0, 1'b1);
            n_cmp++; if (bus.destriped_data_valid_o !== 1'b0) begin n_err++; $display("FAIL part_idle[%0d]: got %b expected 0", p, bus.destriped_data_valid_o); end
        end
    endtask

    task automatic test_backpressure();
        set_t a = rand_set();
        set_t b = rand_set();
        drive(1'b0, 1'b1, 4'hF, a, 1'b1);
        drive(1'b0, 1'b1, 4'hF, b, 1'b1);
        n_cmp++; if (bus.destriped_data_o !== a[0]) begin n_err++; $display("FAIL bp_a0: got %h expected %h", bus.destriped_data_o, a[0]); end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b1, 4'hF, b, 1'b0);
            n_cmp++; if (bus.destriped_data_valid_o !== 1'b1 || bus.destriped_data_o !== a[1]) begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%h expected v=1 d=%h", c, bus.destriped_data_valid_o, bus.destriped_data_o, a[1]); end
            n_cmp++; if (bus.striped_data_ready_o !== 1'b0 || bus.set_done_o !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got rdy=%b done=%b expected 0 0", c, bus.striped_data_ready_o, bus.set_done_o); end
        end
        for (int i = 1; i < NL; i++) begin
            drive(1'b0, (i == NL - 1), 4'hF, b, 1'b1);
            n_cmp++; if (bus.destriped_data_o !== a[i] || bus.set_done_o !== (i == NL - 1)) begin n_err++; $display("FAIL bp_sym[%0d]: got d=%h done=%b expected d=%h done=%b", i, bus.destriped_data_o, bus.set_done_o, a[i], (i == NL - 1)); end
        end
        for (int i = 0; i < NL; i++) begin
            drive(1'b0, 1'b0, 4'hF, '0, 1'b1);
            n_cmp++; if (bus.destriped_data_valid_o !== 1'b1 || bus.destriped_data_o !== b[i]) begin n_err++; $display("FAIL bp_next[%0d]: got v=%b d=%h expected v=1 d=%h", i, bus.destriped_data_valid_o, bus.destriped_data_o, b[i]); end
        end
        drive(1'b0, 1'b0, 4'hF, '0, 1'b1);
    endtask

    task automatic test_cfg_err();
        logic [NL-1:0] pats [3] = '{4'b0000, 4'b0010, 4'b1110};
        foreach (pats[p]) begin
            drive(1'b0, 1'b1, pats[p], rand_set(), 1'b1);
            n_cmp++; if (bus.lane_cfg_err_o !== 1'b1 || bus.striped_data_ready_o !== 1'b1) begin n_err++; $display("FAIL cfg_err_pulse[%0d]: got err=%b rdy=%b expected 1 1", p, bus.lane_cfg_err_o, bus.striped_data_ready_o); end
            drive(1'b0, 1'b0, pats[p], rand_set(), 1'b1);
            n_cmp++; if (bus.lane_cfg_err_o !== 1'b0 || bus.destriped_data_valid_o !== 1'b0) begin n_err++; $display("FAIL cfg_err_after[%0d]: got err=%b v=%b expected 0 0", p, bus.lane_cfg_err_o, bus.destriped_data_valid_o); end
            n_cmp++; if (bus.striped_data_ready_o !== 1'b1) begin n_err++; $display("FAIL cfg_err_idle[%0d]: got rdy=%b expected 1", p, bus.striped_data_ready_o); end
        end
    endtask

    task automatic test_reset_mid_drain();
        set_t a = rand_set();
        set_t b = rand_set();
        drive(1'b0, 1'b1, 4'hF, a, 1'b1);
        drive(1'b0, 1'b0, 4'hF, '0, 1'b1);
        drive(1'b0, 1'b0, 4'hF, '0, 1'b1);
        n_cmp++; if (bus.destriped_data_o !== a[1]) begin n_err++; $display("FAIL rst_mid_a1: got %h expected %h", bus.destriped_data_o, a[1]); end
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 4'hF, '0, 1'b1);
            n_cmp++; if (bus.destriped_data_valid_o !== 1'b0 || bus.set_done_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_out[%0d]: got v=%b done=%b expected 0 0", c, bus.destriped_data_valid_o, bus.set_done_o); end
        end
        drive(1'b0, 1'b1, 4'hF, b, 1'b1);
        n_cmp++; if (bus.striped_data_ready_o !== 1'b1 || bus.destriped_data_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_release: got rdy=%b v=%b expected 1 0", bus.striped_data_ready_o, bus.destriped_data_valid_o); end
        for (int i = 0; i < NL; i++) begin
            drive(1'b0, 1'b0, 4'hF, '0, 1'b1);
            n_cmp++; if (bus.destriped_data_o !== b[i] || bus.set_done_o !== (i == NL - 1)) begin n_err++; $display("FAIL rst_mid_fresh[%0d]: got d=%h done=%b expected d=%h done=%b", i, bus.destriped_data_o, bus.set_done_o, b[i], (i == NL - 1)); end
        end
        drive(1'b0, 1'b0, 4'hF, '0, 1'b1);
    endtask

    // Model: a queue of symbols still owed downstream; a new set may only
    // enter when the queue is empty or its last entry leaves this cycle.
    task automatic test_random();
        logic [DW-1:0] q[$];
        logic          v, rdy, e_valid, e_ready, e_done, e_err;
        logic [NL-1:0] en;
        logic [DW-1:0] e_data;
        set_t          d;
        int            k;
        for (int c = 0; c < 600; c++) begin
            v   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) en = NL'($urandom);
            else en = NL'((1 << $urandom_range(0, NL)) - 1);
            d = rand_set();
            k = kcount(en);
            e_valid = (q.size() > 0);
            e_data  = e_valid ? q[0] : '0;
            e_ready = (q.size() == 0) || (q.size() == 1 && rdy);
            e_done  = (q.size() == 1) && rdy;
            e_err   = v && e_ready && (k == 0);
            drive(1'b0, v, en, d, rdy);
            n_cmp++; if (bus.destriped_data_valid_o !== e_valid || bus.destriped_data_o !== e_data) begin n_err++; $display("FAIL rand_out[%0d]: got v=%b d=%h expected v=%b d=%h", c, bus.destriped_data_valid_o, bus.destriped_data_o, e_valid, e_data); end
            n_cmp++; if (bus.striped_data_ready_o !== e_ready) begin n_err++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, bus.striped_data_ready_o, e_ready); end
            n_cmp++; if (bus.set_done_o !== e_done || bus.lane_cfg_err_o !== e_err) begin n_err++; $display("FAIL rand_pulse[%0d]: got done=%b err=%b expected done=%b err=%b", c, bus.set_done_o, bus.lane_cfg_err_o, e_done, e_err); end
            if (e_valid && rdy) void'(q.pop_front());
            if (v && e_ready) begin
                for (int i = 0; i < k; i++) q.push_back(d[i]);
            end
        end
    endtask

    initial begin
        rst_i                      = 1'b1;
        bus.striped_data_valid_i   = 1'b0;
        bus.lane_enable_i          = '0;
        bus.striped_data_i         = '0;
        bus.destriped_data_ready_i = 1'b0;
        test_reset();
        test_full_set();
        test_back_to_back();
        test_partial_lanes();
        test_backpressure();
        test_cfg_err();
        test_reset_mid_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
